// File: rtl/sram_b_pkg.sv
// Shared definitions for the SRAM bank-B read/write clients: default widths,
// FSM state encodings and the read-credit occupancy helper.
package sram_b_pkg;

  localparam int ABITS_DEF = 12;
  localparam int DBITS_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Words that will occupy the output buffer after this edge if nothing new issues.
  function automatic logic [2:0] occupancy(input logic inflight,
                                           input logic [1:0] count,
                                           input logic pop);
    return {2'b00, inflight} + {1'b0, count} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/sram_b_skid_fifo.sv
// Two-entry FIFO holding {last, data} words captured from the SRAM read port.
// Overflow is prevented upstream by read credits; pop must only be asserted when count != 0.
module sram_b_skid_fifo #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_b_burst_reader.sv
// Burst read client for a 1w:1r SRAM bank: issues sequential reads and turns the
// one-cycle read latency into a lossless valid/ready beat stream.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a burst command; cmd_ready high
// ST_RUN   | issuing reads whenever a buffer credit is available
// ST_DRAIN | all reads issued; waiting for the last word to be consumed
module sram_b_burst_reader
  import sram_b_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ABITS-1:0] cmd_addr,
  input  logic [ABITS-1:0] cmd_len,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_t           state;
  logic [ABITS-1:0] addr;
  logic [ABITS-1:0] rem;
  logic             inflight;
  logic             inflight_last;

  logic [1:0]       count;
  logic [DBITS:0]   head;
  logic             pop;
  logic             issue;
  logic             last_issue;
  logic             drain_done;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;

  // A read may issue only if its word is guaranteed a FIFO slot when it lands.
  assign issue      = (state == ST_RUN) && (occupancy(inflight, count, pop) < 3'd2);
  assign last_issue = issue && (rem == '0);

  assign CE1 = issue;
  assign A1  = issue ? addr : '0;

  // Leave DRAIN on the cycle the final word is consumed so IDLE follows directly.
  assign drain_done = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);

  assign out_last = head[DBITS];
  assign out_data = head[DBITS-1:0];

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state <= ST_RUN;
            addr  <= cmd_addr;
            rem   <= cmd_len;
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
            if (rem == '0) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sram_b_skid_fifo #(
    .W(DBITS + 1)
  ) u_fifo (
    .CLK      (CLK),
    .rst      (rst),
    .push     (inflight),
    .push_data({inflight_last, Q1}),
    .pop      (pop),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_sram_b_burst_reader.sv
// Self-checking bench for sram_b_burst_reader: SRAM model, transaction-level
// scoreboard of expected read addresses and beats, plus directed timing checks.
module tb_sram_b_burst_reader;

  logic        CLK;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        CE1;
  logic [11:0] A1;
  logic [7:0]  Q1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int beat_cnt = 0;
  int last_cnt = 0;
  int outst = 0;

  logic [7:0]  mem [4096];
  logic [11:0] exp_a [$];
  logic [8:0]  exp_b [$];
  logic [11:0] mon_a;
  logic [8:0]  mon_b;
  logic        hold_prev = 1'b0;
  logic [7:0]  hold_data;
  logic        hold_last;

  sram_b_burst_reader dut (
    .CLK      (CLK),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .CE1      (CE1),
    .A1       (A1),
    .Q1       (Q1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial Q1 = 8'h00;
  always @(posedge CLK) if (CE1) Q1 <= mem[A1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every read address and every delivered beat is matched against
  // the list derived from the accepted command.
  always @(negedge CLK) begin
    if (!rst) begin
      exp_a.delete();
      exp_b.delete();
      outst = 0;
      hold_prev = 1'b0;
    end else begin
      if (CE1) begin
        chk("read_expected", 32'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) begin
          mon_a = exp_a.pop_front();
          chk("A1_seq", 32'(A1), 32'(mon_a));
        end
        outst++;
      end else begin
        chk("A1_zero_when_idle", 32'(A1), 0);
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
        chk("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) begin
          mon_b = exp_b.pop_front();
          chk("beat_data", 32'(out_data), 32'(mon_b[7:0]));
          chk("beat_last", 32'(out_last), 32'(mon_b[8]));
        end
        outst--;
        beat_cnt++;
        if (out_last) last_cnt++;
      end
      chk("outstanding_le2", 32'(outst <= 2), 1);
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i <= int'(cmd_len); i++) begin
          mon_a = 12'(int'(cmd_addr) + i);
          exp_a.push_back(mon_a);
          exp_b.push_back({(i == int'(cmd_len)), mem[mon_a]});
        end
      end
    end
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1 with cmd_ready high; returns at posedge+1 of cycle 1.
  task automatic send_cmd(input logic [11:0] a, input logic [11:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    nxt();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int lim, input bit rnd_rdy, input bit rnd_cmd);
    int n = 0;
    while (!cmd_ready && n < lim) begin
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_valid = rnd_cmd ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_addr  = 12'($urandom);
      cmd_len   = 12'($urandom);
      nxt();
      n++;
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    chk("idle_timeout", 32'(cmd_ready), 1);
    chk("scoreboard_empty", 32'(exp_b.size()), 0);
  endtask

  initial begin
    int b0;
    logic [11:0] base;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h010] = 8'hA5;

    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_CE1", 32'(CE1), 0);
    chk("rst_A1", 32'(A1), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    out_ready = 1'b1;
    nxt();

    // single beat
    send_cmd(12'h010, 12'h000);
    @(negedge CLK);
    chk("single_CE1_c1", 32'(CE1), 1);
    chk("single_A1_c1", 32'(A1), 32'h010);
    nxt();
    @(negedge CLK);
    chk("single_valid_c2", 32'(out_valid), 0);
    chk("single_CE1_c2", 32'(CE1), 0);
    nxt();
    @(negedge CLK);
    chk("single_valid_c3", 32'(out_valid), 1);
    chk("single_data_c3", 32'(out_data), 32'hA5);
    chk("single_last_c3", 32'(out_last), 1);
    chk("single_ready_c3", 32'(cmd_ready), 0);
    nxt();
    @(negedge CLK);
    chk("single_ready_c4", 32'(cmd_ready), 1);
    chk("single_busy_c4", 32'(busy), 0);
    nxt();

    // full-rate 4-beat burst
    send_cmd(12'h100, 12'h003);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      if (c <= 4) begin
        chk("burst_CE1", 32'(CE1), 1);
        chk("burst_A1", 32'(A1), 32'(32'h100 + c - 1));
      end else begin
        chk("burst_CE1_off", 32'(CE1), 0);
      end
      if (c >= 3 && c <= 6) begin
        chk("burst_valid", 32'(out_valid), 1);
        chk("burst_data", 32'(out_data), 32'(mem[12'(32'h100 + c - 3)]));
        chk("burst_last", 32'(out_last), 32'(c == 6));
      end else begin
        chk("burst_valid_off", 32'(out_valid), 0);
      end
      if (c == 7) chk("burst_ready_c7", 32'(cmd_ready), 1);
      if (c < 7) nxt();
    end
    nxt();

    // backpressure: out_ready low in cycles 3..10
    base = 12'h200 + 12'($urandom_range(0, 255));
    b0 = beat_cnt;
    send_cmd(base, 12'h007);
    for (int c = 1; c <= 10; c++) begin
      out_ready = (c >= 3) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (c <= 2) chk("bp_CE1_on", 32'(CE1), 1);
      else        chk("bp_CE1_off", 32'(CE1), 0);
      if (c >= 3) begin
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_beat0", 32'(out_data), 32'(mem[base]));
      end
      nxt();
    end
    out_ready = 1'b1;
    run_until_idle(100, 1'b0, 1'b0);
    chk("bp_beats", 32'(beat_cnt - b0), 8);
    nxt();

    // address wrap
    send_cmd(12'hFFE, 12'h003);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      chk("wrap_CE1", 32'(CE1), 1);
      chk("wrap_A1", 32'(A1), 32'((32'hFFE + c - 1) % 4096));
      nxt();
    end
    run_until_idle(100, 1'b0, 1'b0);
    nxt();

    // random bursts
    for (int k = 0; k < 4; k++) begin
      send_cmd(12'($urandom), 12'($urandom_range(0, 20)));
      run_until_idle(500, 1'b1, 1'b1);
      nxt();
    end

    // maximum length with random out_ready and ignored commands
    b0 = beat_cnt;
    last_cnt = 0;
    send_cmd(12'($urandom), 12'hFFF);
    run_until_idle(20000, 1'b1, 1'b1);
    chk("max_beats", 32'(beat_cnt - b0), 4096);
    chk("max_lasts", 32'(last_cnt), 1);
    nxt();

    // reset during beat 2 of an 8-beat burst
    send_cmd(12'h300, 12'h007);
    repeat (4) nxt();
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_CE1", 32'(CE1), 0);
    chk("mid_rst_A1", 32'(A1), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    chk("mid_rst_out_last", 32'(out_last), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    nxt();
    nxt();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_CE1", 32'(CE1), 0);
      nxt();
    end
    b0 = beat_cnt;
    send_cmd(12'($urandom), 12'h005);
    run_until_idle(200, 1'b1, 1'b0);
    chk("post_rst_beats", 32'(beat_cnt - b0), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
